// File: rtl/axi_lite_reg_bridge_if.sv
// AXI4-Lite subordinate-side bus bundle for the register bridge.
// master drives AW/W/AR and B/R ready; slave drives the rest.
interface axi_lite_reg_bridge_if #(
  parameter int AXI_AW = 12,
  parameter int REG_DW = 32
);
  logic [AXI_AW-1:0]   s_awaddr;
  logic                s_awvalid;
  logic                s_awready;
  logic [REG_DW-1:0]   s_wdata;
  logic [REG_DW/8-1:0] s_wstrb;
  logic                s_wvalid;
  logic                s_wready;
  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready;
  logic [AXI_AW-1:0]   s_araddr;
  logic                s_arvalid;
  logic                s_arready;
  logic [REG_DW-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rvalid;
  logic                s_rready;

  modport master (
    output s_awaddr, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wvalid,
    input  s_wready,
    input  s_bresp, s_bvalid,
    output s_bready,
    output s_araddr, s_arvalid,
    input  s_arready,
    input  s_rdata, s_rresp, s_rvalid,
    output s_rready
  );

  modport slave (
    input  s_awaddr, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wvalid,
    output s_wready,
    output s_bresp, s_bvalid,
    input  s_bready,
    input  s_araddr, s_arvalid,
    output s_arready,
    output s_rdata, s_rresp, s_rvalid,
    input  s_rready
  );
endinterface

// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite to CSR register-bus bridge: one-entry AW/W/AR buffers,
// round-robin grant, single-cycle reg_write/reg_read strobes.
// Ports: clk, arst_n, s (AXI slave modport), reg_addr/reg_wdata/
// reg_write/reg_read out, reg_rdata/access_violation in.
module axi_lite_reg_bridge #(
  parameter int REG_DW = 32,
  parameter int REG_AW = 4,
  parameter int AXI_AW = 12
) (
  input  logic              clk,
  input  logic              arst_n,
  axi_lite_reg_bridge_if.slave s,
  output logic [REG_AW-1:0] reg_addr,
  output logic [REG_DW-1:0] reg_wdata,
  output logic              reg_write,
  output logic              reg_read,
  input  logic [REG_DW-1:0] reg_rdata,
  input  logic [1:0]        access_violation
);

  localparam int SW = REG_DW / 8;
  localparam int WW = AXI_AW - 2;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_ACC,
    WR_RESP,
    RD_ACC,
    RD_RESP
  } state_e;

  function automatic logic [1:0] map_viol(input logic [1:0] v);
    logic [1:0] r;
    unique case (v)
      2'd0:    r = OKAY;
      2'd1:    r = SLVERR;
      2'd2:    r = SLVERR;
      default: r = DECERR;
    endcase
    return r;
  endfunction

  state_e state_q, state_d;

  logic run_q, run_d;

  logic          aw_full_q, aw_full_d;
  logic [WW-1:0] aw_word_q, aw_word_d;
  logic          w_full_q, w_full_d;
  logic [REG_DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          ar_full_q, ar_full_d;
  logic [WW-1:0] ar_word_q, ar_word_d;

  logic       wr_req_q, wr_req_d;
  logic [1:0] wr_err_q, wr_err_d;
  logic       rd_req_q, rd_req_d;
  logic [1:0] rd_err_q, rd_err_d;
  logic       rr_q, rr_d;

  logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
  logic [REG_DW-1:0] reg_wdata_q, reg_wdata_d;
  logic reg_write_q, reg_write_d;
  logic reg_read_q, reg_read_d;

  logic       bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;
  logic       rvalid_q, rvalid_d;
  logic [1:0] rresp_q, rresp_d;
  logic [REG_DW-1:0] rdata_q, rdata_d;

  logic awready, wready, arready;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic grant_wr, grant_rd;

  // readies stay low while in reset and come up one edge later
  assign awready = run_q & ~aw_full_q;
  assign wready  = run_q & ~w_full_q;
  assign arready = run_q & ~ar_full_q;

  assign aw_hs = s.s_awvalid & awready;
  assign w_hs  = s.s_wvalid & wready;
  assign ar_hs = s.s_arvalid & arready;
  assign b_hs  = bvalid_q & s.s_bready;
  assign r_hs  = rvalid_q & s.s_rready;

  assign grant_wr = wr_req_q & (~rd_req_q | ~rr_q);
  assign grant_rd = rd_req_q & ~grant_wr;

  always_comb begin
    state_d     = state_q;
    run_d       = 1'b1;
    aw_full_d   = aw_full_q;
    aw_word_d   = aw_word_q;
    w_full_d    = w_full_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    ar_full_d   = ar_full_q;
    ar_word_d   = ar_word_q;
    rr_d        = rr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_write_d = 1'b0;
    reg_read_d  = 1'b0;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_word_d = s.s_awaddr[AXI_AW-1:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = s.s_wdata;
      wstrb_d  = s.s_wstrb;
    end
    if (ar_hs) begin
      ar_full_d = 1'b1;
      ar_word_d = s.s_araddr[AXI_AW-1:2];
    end
    if (b_hs) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
    if (r_hs) begin
      ar_full_d = 1'b0;
    end

    // request/decode stage: local checks are registered ahead of
    // the grant; the drop on b_hs/r_hs keeps a stale request from
    // surviving the buffer release
    wr_req_d = aw_full_q & w_full_q & ~b_hs;
    rd_req_d = ar_full_q & ~r_hs;

    if (|aw_word_q[WW-1:REG_AW]) begin
      wr_err_d = DECERR;
    end else if (wstrb_q != '1) begin
      wr_err_d = SLVERR;
    end else begin
      wr_err_d = OKAY;
    end
    rd_err_d = (|ar_word_q[WW-1:REG_AW]) ? DECERR : OKAY;

    unique case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d = WR_ACC;
          rr_d    = ~rr_q;
          if (wr_err_q == OKAY) begin
            reg_write_d = 1'b1;
            reg_addr_d  = aw_word_q[REG_AW-1:0];
            reg_wdata_d = wdata_q;
          end
        end else if (grant_rd) begin
          state_d = RD_ACC;
          rr_d    = ~rr_q;
          if (rd_err_q == OKAY) begin
            reg_read_d = 1'b1;
            reg_addr_d = ar_word_q[REG_AW-1:0];
          end
        end
      end
      WR_ACC: begin
        state_d  = WR_RESP;
        bvalid_d = 1'b1;
        bresp_d  = reg_write_q ? map_viol(access_violation)
                               : wr_err_q;
      end
      WR_RESP: begin
        if (b_hs) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
        end
      end
      RD_ACC: begin
        state_d  = RD_RESP;
        rvalid_d = 1'b1;
        if (reg_read_q) begin
          rresp_d = map_viol(access_violation);
          rdata_d = (access_violation == 2'd0) ? reg_rdata : '0;
        end else begin
          rresp_d = rd_err_q;
          rdata_d = '0;
        end
      end
      RD_RESP: begin
        if (r_hs) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      aw_full_q   <= 1'b0;
      aw_word_q   <= '0;
      w_full_q    <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      ar_full_q   <= 1'b0;
      ar_word_q   <= '0;
      wr_req_q    <= 1'b0;
      wr_err_q    <= OKAY;
      rd_req_q    <= 1'b0;
      rd_err_q    <= OKAY;
      rr_q        <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_write_q <= 1'b0;
      reg_read_q  <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= OKAY;
      rvalid_q    <= 1'b0;
      rresp_q     <= OKAY;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      aw_full_q   <= aw_full_d;
      aw_word_q   <= aw_word_d;
      w_full_q    <= w_full_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      ar_full_q   <= ar_full_d;
      ar_word_q   <= ar_word_d;
      wr_req_q    <= wr_req_d;
      wr_err_q    <= wr_err_d;
      rd_req_q    <= rd_req_d;
      rd_err_q    <= rd_err_d;
      rr_q        <= rr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_write_q <= reg_write_d;
      reg_read_q  <= reg_read_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
    end
  end

  assign s.s_awready = awready;
  assign s.s_wready  = wready;
  assign s.s_arready = arready;
  assign s.s_bvalid  = bvalid_q;
  assign s.s_bresp   = bresp_q;
  assign s.s_rvalid  = rvalid_q;
  assign s.s_rresp   = rresp_q;
  assign s.s_rdata   = rdata_q;

  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_write = reg_write_q;
  assign reg_read  = reg_read_q;

endmodule
